// File: rtl/pwm_fb_bus_collect_if.sv
// Bundle of feedback pins, fault-clear and filtered/latched buses for
// pwm_fb_bus_collect. The first-fault record signals exist only when
// FB_FIRST_FAULT_EN is defined.
// master: feedback source / consumer side; slave: the collector itself.
interface pwm_fb_bus_collect_if #(
    parameter int WIDTH = 48
);
    logic [WIDTH-1:0] fb_a_raw;
    logic [WIDTH-1:0] fb_b_raw;
    logic [WIDTH-1:0] fb_c_raw;
    logic             flt_clr;
    logic [WIDTH-1:0] fb_a_bus;
    logic [WIDTH-1:0] fb_b_bus;
    logic [WIDTH-1:0] fb_c_bus;
    logic [WIDTH-1:0] flt_a_bus;
    logic [WIDTH-1:0] flt_b_bus;
    logic [WIDTH-1:0] flt_c_bus;
    logic             flt_any;
    logic             chg_stb;
`ifdef FB_FIRST_FAULT_EN
    logic             first_vld;
    logic [7:0]       first_idx;

    modport master (
        output fb_a_raw, fb_b_raw, fb_c_raw, flt_clr,
        input  fb_a_bus, fb_b_bus, fb_c_bus,
        input  flt_a_bus, flt_b_bus, flt_c_bus, flt_any, chg_stb,
        input  first_vld, first_idx
    );

    modport slave (
        input  fb_a_raw, fb_b_raw, fb_c_raw, flt_clr,
        output fb_a_bus, fb_b_bus, fb_c_bus,
        output flt_a_bus, flt_b_bus, flt_c_bus, flt_any, chg_stb,
        output first_vld, first_idx
    );
`else
    modport master (
        output fb_a_raw, fb_b_raw, fb_c_raw, flt_clr,
        input  fb_a_bus, fb_b_bus, fb_c_bus,
        input  flt_a_bus, flt_b_bus, flt_c_bus, flt_any, chg_stb
    );

    modport slave (
        input  fb_a_raw, fb_b_raw, fb_c_raw, flt_clr,
        output fb_a_bus, fb_b_bus, fb_c_bus,
        output flt_a_bus, flt_b_bus, flt_c_bus, flt_any, chg_stb
    );
`endif
endinterface

// File: rtl/pwm_fb_bus_collect.sv
// pwm_fb_bus_collect: gate-driver feedback collector for phases A/B/C.
// Each bit is synchronised (2 flops), glitch-filtered (FILT_LEN stable
// samples) and feeds a fault latch that holds until FLT_CLR while the
// filtered bit is low. Bit order follows the PWM gate buses
// (bit WIDTH-1 = SM1 switch A ... bit 0 = SM24 switch B).
// Optional feature macro: FB_FIRST_FAULT_EN adds a first-fault record
// (first_vld / first_idx = {phase[1:0], bit[5:0]}).
module pwm_fb_bus_collect #(
    parameter int WIDTH    = 48,
    parameter int FILT_LEN = 8,
    parameter int CW       = 8,
    parameter bit FB_INV   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    pwm_fb_bus_collect_if.slave bus
);
    localparam int NPH = 3;
    localparam logic [CW-1:0] CNT_TC = CW'(FILT_LEN - 1);

    logic [WIDTH-1:0] raw       [NPH];
    logic [WIDTH-1:0] sync1     [NPH];
    logic [WIDTH-1:0] sync2     [NPH];
    logic [WIDTH-1:0] filt      [NPH];
    logic [WIDTH-1:0] filt_prev [NPH];
    logic [WIDTH-1:0] latch     [NPH];
    logic [CW-1:0]    cnt       [NPH][WIDTH];
    logic             chg_stb;

    // Active-low drivers are flipped before the synchroniser so the rest of
    // the block always sees 1 = feedback asserted.
    assign raw[0] = FB_INV ? ~bus.fb_a_raw : bus.fb_a_raw;
    assign raw[1] = FB_INV ? ~bus.fb_b_raw : bus.fb_b_raw;
    assign raw[2] = FB_INV ? ~bus.fb_c_raw : bus.fb_c_raw;

    // Two-flop synchroniser per feedback bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPH; p++) begin
                sync1[p] <= '0;
                sync2[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPH; p++) begin
                sync1[p] <= raw[p];
                sync2[p] <= sync1[p];
            end
        end
    end

    // Glitch filter: accept a new level only after FILT_LEN consecutive
    // differing samples; any matching sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPH; p++) begin
                filt[p] <= '0;
                for (int b = 0; b < WIDTH; b++) begin
                    cnt[p][b] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NPH; p++) begin
                for (int b = 0; b < WIDTH; b++) begin
                    if (sync2[p][b] == filt[p][b]) begin
                        cnt[p][b] <= '0;
                    end else if (cnt[p][b] == CNT_TC) begin
                        filt[p][b] <= sync2[p][b];
                        cnt[p][b]  <= '0;
                    end else begin
                        cnt[p][b] <= cnt[p][b] + 1'b1;
                    end
                end
            end
        end
    end

    // Fault latches (an active fault overrides clear) and the change strobe,
    // which compares against last cycle's filtered value so it lands one
    // cycle after the filtered bus moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPH; p++) begin
                latch[p]     <= '0;
                filt_prev[p] <= '0;
            end
            chg_stb <= 1'b0;
        end else begin
            for (int p = 0; p < NPH; p++) begin
                latch[p]     <= filt[p] | (latch[p] & {WIDTH{~bus.flt_clr}});
                filt_prev[p] <= filt[p];
            end
            chg_stb <= |((filt[0] ^ filt_prev[0]) |
                         (filt[1] ^ filt_prev[1]) |
                         (filt[2] ^ filt_prev[2]));
        end
    end

    assign bus.fb_a_bus  = filt[0];
    assign bus.fb_b_bus  = filt[1];
    assign bus.fb_c_bus  = filt[2];
    assign bus.flt_a_bus = latch[0];
    assign bus.flt_b_bus = latch[1];
    assign bus.flt_c_bus = latch[2];
    assign bus.flt_any   = (|latch[0]) | (|latch[1]) | (|latch[2]);
    assign bus.chg_stb   = chg_stb;

`ifdef FB_FIRST_FAULT_EN
    logic [7:0] prio_idx;
    logic       first_vld;
    logic [7:0] first_idx;

    // Priority pick: later assignments win, so scan from lowest priority
    // (phase C, bit 0) up to highest (phase A, top bit).
    always_comb begin
        prio_idx = '0;
        for (int p = NPH - 1; p >= 0; p--) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (latch[p][b]) begin
                    prio_idx = {2'(p), 6'(b)};
                end
            end
        end
    end

    // First-fault record: capture once, hold until clear, recapture if a
    // latch survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_vld <= 1'b0;
            first_idx <= '0;
        end else if (bus.flt_clr) begin
            first_vld <= 1'b0;
            first_idx <= '0;
        end else if (!first_vld && bus.flt_any) begin
            first_vld <= 1'b1;
            first_idx <= prio_idx;
        end
    end

    assign bus.first_vld = first_vld;
    assign bus.first_idx = first_idx;
`endif

endmodule

// File: tb/tb_pwm_fb_bus_collect.sv
// Testbench for pwm_fb_bus_collect: directed scenarios plus randomized
// bit toggling, compared cycle by cycle against a history-window model.
// A second instance with inverted pins is held at all-ones throughout.
module tb_pwm_fb_bus_collect;
    localparam int W  = 48;
    localparam int FL = 8;
    localparam int HD = FL + 2;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    pwm_fb_bus_collect_if #(.WIDTH(W)) bus ();
    pwm_fb_bus_collect_if #(.WIDTH(W)) bus_inv ();

    pwm_fb_bus_collect #(.WIDTH(W), .FILT_LEN(FL), .CW(8), .FB_INV(1'b0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pwm_fb_bus_collect #(.WIDTH(W), .FILT_LEN(FL), .CW(8), .FB_INV(1'b1)) u_dut_inv (
        .clk (clk),
        .rst (rst),
        .bus (bus_inv.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a bit's filtered level flips once its last FL
    // synchronised samples (raw delayed by two clocks) all disagree with it.
    logic [W-1:0] rh [3][HD];
    logic [W-1:0] m_filt [3];
    logic [W-1:0] m_flt [3];
    logic [W-1:0] nf [3];
    logic [W-1:0] cur_raw [3];
    logic         m_chg;
    logic         m_tog;
    logic         m_vld;
    logic [7:0]   m_idx;
    logic         found;
    int           ndiff;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 3; p++) begin
                m_filt[p] = '0;
                m_flt[p]  = '0;
                for (int j = 0; j < HD; j++) rh[p][j] = '0;
            end
            m_chg = 1'b0;
            m_tog = 1'b0;
            m_vld = 1'b0;
            m_idx = '0;
        end else begin
            cur_raw[0] = bus.fb_a_raw;
            cur_raw[1] = bus.fb_b_raw;
            cur_raw[2] = bus.fb_c_raw;
            for (int p = 0; p < 3; p++) begin
                nf[p] = m_filt[p];
                for (int b = 0; b < W; b++) begin
                    ndiff = 0;
                    for (int j = 0; j < FL; j++)
                        if (rh[p][1 + j][b] != m_filt[p][b]) ndiff++;
                    if (ndiff == FL) nf[p][b] = ~m_filt[p][b];
                end
            end
            if (bus.flt_clr) begin
                m_vld = 1'b0;
                m_idx = '0;
            end else if (!m_vld && ((|m_flt[0]) || (|m_flt[1]) || (|m_flt[2]))) begin
                found = 1'b0;
                for (int p = 0; p < 3; p++)
                    for (int b = W - 1; b >= 0; b--)
                        if (!found && m_flt[p][b]) begin
                            found = 1'b1;
                            m_idx = 8'(p * 64 + b);
                        end
                m_vld = 1'b1;
            end
            for (int p = 0; p < 3; p++)
                m_flt[p] = m_filt[p] | (bus.flt_clr ? '0 : m_flt[p]);
            m_chg = m_tog;
            m_tog = 1'b0;
            for (int p = 0; p < 3; p++) begin
                if (nf[p] != m_filt[p]) m_tog = 1'b1;
                m_filt[p] = nf[p];
                for (int j = HD - 1; j > 0; j--) rh[p][j] = rh[p][j - 1];
                rh[p][0] = cur_raw[p];
            end
        end
    end

    task automatic cmp_all();
        chk("fb_a", 64'(bus.fb_a_bus), 64'(m_filt[0]));
        chk("fb_b", 64'(bus.fb_b_bus), 64'(m_filt[1]));
        chk("fb_c", 64'(bus.fb_c_bus), 64'(m_filt[2]));
        chk("flt_a", 64'(bus.flt_a_bus), 64'(m_flt[0]));
        chk("flt_b", 64'(bus.flt_b_bus), 64'(m_flt[1]));
        chk("flt_c", 64'(bus.flt_c_bus), 64'(m_flt[2]));
        chk("flt_any", 64'(bus.flt_any), 64'((|m_flt[0]) | (|m_flt[1]) | (|m_flt[2])));
        chk("chg_stb", 64'(bus.chg_stb), 64'(m_chg));
`ifdef FB_FIRST_FAULT_EN
        chk("first_vld", 64'(bus.first_vld), 64'(m_vld));
        chk("first_idx", 64'(bus.first_idx), 64'(m_idx));
`endif
        chk("inv_fb", 64'(bus_inv.fb_a_bus | bus_inv.fb_b_bus | bus_inv.fb_c_bus), 64'd0);
        chk("inv_flt", 64'(bus_inv.flt_any), 64'd0);
        chk("inv_chg", 64'(bus_inv.chg_stb), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    initial begin
        int chg_seen;
        rst = 1'b0;
        bus.fb_a_raw = '0;
        bus.fb_b_raw = '0;
        bus.fb_c_raw = '0;
        bus.flt_clr  = 1'b0;
        bus_inv.fb_a_raw = '1;
        bus_inv.fb_b_raw = '1;
        bus_inv.fb_c_raw = '1;
        bus_inv.flt_clr  = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_all();

        // Rising feedback on A[47]: filtered after 10 cycles, latch and strobe one later.
        bus.fb_a_raw[47] = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 9) chk("t2_fb_early", 64'(bus.fb_a_bus[47]), 64'd0);
            if (i == 10) begin
                chk("t2_fb_rise", 64'(bus.fb_a_bus[47]), 64'd1);
                chk("t2_chg_not_yet", 64'(bus.chg_stb), 64'd0);
            end
            if (i == 11) begin
                chk("t2_chg", 64'(bus.chg_stb), 64'd1);
                chk("t2_flt", 64'(bus.flt_a_bus[47]), 64'd1);
                chk("t2_any", 64'(bus.flt_any), 64'd1);
            end
        end

        // Clear with the fault still active is ignored; clear after it drops works.
        bus.flt_clr = 1'b1;
        step();
        bus.flt_clr = 1'b0;
        chk("t4_hold", 64'(bus.flt_a_bus[47]), 64'd1);
        bus.fb_a_raw[47] = 1'b0;
        repeat (11) step();
        bus.flt_clr = 1'b1;
        step();
        bus.flt_clr = 1'b0;
        chk("t4_cleared", 64'(bus.flt_a_bus[47]), 64'd0);
        chk("t4_any", 64'(bus.flt_any), 64'd0);

        // Seven-sample pulse on B[0] is one short of the filter length.
        bus.fb_b_raw[0] = 1'b1;
        chg_seen = 0;
        repeat (7) begin
            step();
            if (bus.chg_stb) chg_seen++;
        end
        bus.fb_b_raw[0] = 1'b0;
        repeat (14) begin
            step();
            if (bus.chg_stb) chg_seen++;
        end
        chk("t3_chg", 64'(chg_seen), 64'd0);
        chk("t3_fb", 64'(bus.fb_b_bus), 64'd0);
        chk("t3_flt", 64'(bus.flt_b_bus), 64'd0);

`ifdef FB_FIRST_FAULT_EN
        // Simultaneous B[10] and C[47]: phase B outranks C.
        bus.fb_b_raw[10] = 1'b1;
        bus.fb_c_raw[47] = 1'b1;
        repeat (12) step();
        chk("t5_vld", 64'(bus.first_vld), 64'd1);
        chk("t5_idx", 64'(bus.first_idx), 64'h4A);
        bus.fb_b_raw[10] = 1'b0;
        bus.fb_c_raw[47] = 1'b0;
        repeat (12) step();
`endif

        // Randomized toggling with occasional clears; asynchronous reset mid-run.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0: bus.fb_a_raw[$urandom_range(0, W - 1)] ^= 1'b1;
                    1: bus.fb_b_raw[$urandom_range(0, W - 1)] ^= 1'b1;
                    default: bus.fb_c_raw[$urandom_range(0, W - 1)] ^= 1'b1;
                endcase
            end
            bus.flt_clr = ($urandom_range(0, 15) == 0);
            step();
            if (cyc == 1000) begin
                bus.fb_c_raw[5] = ~bus.fb_c_raw[5];
                step();
                step();
                step();
                #1 rst = 1'b1;
                #1;
                chk("rst_fb", 64'(bus.fb_a_bus | bus.fb_b_bus | bus.fb_c_bus), 64'd0);
                chk("rst_flt", 64'(bus.flt_a_bus | bus.flt_b_bus | bus.flt_c_bus), 64'd0);
                chk("rst_any", 64'(bus.flt_any), 64'd0);
                chk("rst_chg", 64'(bus.chg_stb), 64'd0);
`ifdef FB_FIRST_FAULT_EN
                chk("rst_first", 64'({bus.first_vld, bus.first_idx}), 64'd0);
`endif
                @(negedge clk);
                rst = 1'b0;
                cmp_all();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
